sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable single-bank SDR SDRAM responder: the device end of the SDRAM command interface our controller/testbench drives.
- Decodes RAS/CAS/WE commands and manages an open row, mode register, CAS latency and bursts.
- Backs storage with an inferred block-RAM array.
- Used in verilator and on-FPGA loopback builds in place of a real chip; flags protocol violations so controller bugs surface as counts rather than silent corruption.

Parameters:
- ROW_BITS, 6, row address width taken from addr[ROW_BITS-1:0] on ACTIVE.
- COL_BITS, 8, column address width taken from addr[COL_BITS-1:0] on READ/WRITE.
- Memory depth is 2^(ROW_BITS+COL_BITS) 16-bit words, indexed {row,col}.

Ports:
- clk  in  1  command/data clock; all commands sampled on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sdram_ras_n  in  1  row strobe.
- sdram_cas_n  in  1  column strobe.
- sdram_we_n  in  1  write enable.
- sdram_addr  in  12  address / mode bits; addr[10] = auto/all flag.
- sdram_data_i  in  16  write data from controller.
- sdram_data_o  out  16  read data to controller.
- sdram_data_oe  out  1  high while responder drives read data.
- err  out  1  sticky protocol-violation flag.
- err_count  out  8  saturating violation count.
- refresh_count  out  16  wrapping count of REFRESH commands.

Behaviour:
- Reset (async, rst_n low):
  - data_o=0, data_oe=0, err=0, err_count=0, refresh_count=0.
  - No row open; burst idle; read pipeline cleared.
  - Mode: CL=2, BL=1.
  - Memory contents are not reset.
- Command decode on {ras_n,cas_n,we_n}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 REFRESH, 000 LOAD_MODE.
- ACTIVE: latch row, set row_open. If a row is already open: violation; row is still replaced.
- PRECHARGE: clear row_open; terminate any burst (including read data still in the CL pipe). Precharging with no row open is legal (no violation).
- REFRESH: refresh_count+1. If a row is open or a burst is active: violation; the refresh is still counted.
- LOAD_MODE:
  - CL = addr[6:4]; legal values 2, 3.
  - BL = addr[2:0]; 0,1,2,3 encode 1,2,4,8.
  - Any other value: violation, old field kept.
  - Issued with a row open: violation, register still loads.
- WRITE:
  - Word at {row,addr col} <= data_i in the same cycle.
  - Remaining BL-1 beats take data_i on successive cycles; column increments and wraps within the BL-aligned block, with low log2(BL) bits wrapping.
  - Example: BL=4, col 0x06 -> 06,07,04,05.
- READ:
  - Beat i address follows the same wrap rule as WRITE.
  - A READ sampled at edge N places beat i on data_o with data_oe=1 after edge N+CL-1+i, so the controller samples it at edge N+CL+i.
  - Read pipeline depth is at most 3; RAM read is registered.
- READ or WRITE with no row open: violation, command ignored (no memory write, no data driven).
- Burst interruption: a new READ/WRITE/PRECHARGE terminates the current burst.
  - A READ interrupting a READ lets the already-issued beats complete up to the new read's first data; the new burst then takes over (seamless).
  - A WRITE during read data output: read beats not yet driven are dropped; data_oe falls the cycle the WRITE is sampled.
- data_oe is 0 except during read beats. data_o holds its last value when oe=0.
- Violations: err set sticky; err_count saturates at 255.
- A violation and a legal effect in the same cycle both occur as specified above.
- Reset asserted mid-burst: data_oe drops immediately (asynchronous); a write in progress stops, already-written words stay.

Test Plan:
- Reset, LOAD_MODE addr=0x020 (CL2, BL1), ACTIVE row 3, WRITE col 0x10 data 0xBEEF, READ col 0x10 -> data_oe=1 and data_o=0xBEEF sampled exactly 2 edges after READ; err=0.
- LOAD_MODE addr=0x032 (CL3, BL4), ACTIVE row 1, WRITE col 0x06 with data 0x1111,0x2222,0x3333,0x4444, READ col 0x04 -> beats 0x3333,0x4444,0x1111,0x2222 starting at edge N+3.
- READ with no row open, then ACTIVE twice -> no data_oe, err=1, err_count=2.
- BL4 read interrupted by PRECHARGE on the cycle after READ with CL3 -> data_oe never asserts.
- 300 REFRESH with no row open -> refresh_count=300, err=0. Then 260 violations -> err_count=255.
- rst_n pulsed low during a BL8 read beat 3 -> data_oe=0 within the same cycle, mode reverts to CL2/BL1, earlier written data still readable.

Source files
------------

// File: rtl/sdram_responder.sv
// Single-bank SDR SDRAM device model: decodes RAS/CAS/WE, tracks the open row,
// mode register and bursts, returns read data after CAS latency, counts protocol violations.
module sdram_responder #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [11:0] sdram_addr,
    input  logic [15:0] sdram_data_i,
    output logic [15:0] sdram_data_o,
    output logic        sdram_data_oe,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] refresh_count
);
    localparam int AW = ROW_BITS + COL_BITS;

    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;

    typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_e;

    logic [15:0]         mem [0:(1<<AW)-1];
    logic [2:0]          cmd;
    logic                is_act, is_pre, is_ref, is_lm, is_rd, is_wr, rd_ok, wr_ok;
    logic                cl_ok, bl_ok, viol, flush;
    logic [ROW_BITS-1:0] row_q;
    logic                row_open_q;
    logic                cl3_q;
    logic [1:0]          bl_code_q;
    logic [COL_BITS-1:0] cmd_col, mode_mask;
    burst_e              burst_q, burst_d;
    logic [COL_BITS-1:0] bcol_q, bcol_d, bmask_q, bmask_d;
    logic [2:0]          bleft_q, bleft_d;
    logic                req_v, wr_en;
    logic [AW-1:0]       req_a, wr_a;
    logic                p1_v, p2_v, out_v;
    logic [AW-1:0]       p1_a, p2_a, out_a;
    logic                unused_addr;

    function automatic logic [COL_BITS-1:0] wrap_inc(input logic [COL_BITS-1:0] col,
                                                     input logic [COL_BITS-1:0] mask);
        return (col & ~mask) | ((col + COL_BITS'(1)) & mask);
    endfunction

    assign cmd         = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_act      = (cmd == CMD_ACTIVE);
    assign is_pre      = (cmd == CMD_PRECHARGE);
    assign is_ref      = (cmd == CMD_REFRESH);
    assign is_lm       = (cmd == CMD_LOAD_MODE);
    assign is_rd       = (cmd == CMD_READ);
    assign is_wr       = (cmd == CMD_WRITE);
    assign rd_ok       = is_rd && row_open_q;
    assign wr_ok       = is_wr && row_open_q;
    assign cmd_col     = sdram_addr[COL_BITS-1:0];
    assign mode_mask   = COL_BITS'((1 << bl_code_q) - 1);
    assign cl_ok       = (sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3);
    assign bl_ok       = !sdram_addr[2];
    assign flush       = is_pre || wr_ok;
    assign unused_addr = ^sdram_addr;

    assign viol = (is_act && row_open_q)
               || (is_ref && (row_open_q || burst_q != B_IDLE))
               || ((is_rd || is_wr) && !row_open_q)
               || (is_lm && (!cl_ok || !bl_ok || row_open_q));

    // Burst sequencer: beat 0 comes straight from the command, later beats from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= B_IDLE;
            bcol_q  <= '0;
            bmask_q <= '0;
            bleft_q <= '0;
        end else begin
            burst_q <= burst_d;
            bcol_q  <= bcol_d;
            bmask_q <= bmask_d;
            bleft_q <= bleft_d;
        end
    end

    always_comb begin
        burst_d = burst_q;
        bcol_d  = bcol_q;
        bmask_d = bmask_q;
        bleft_d = bleft_q;
        req_v   = 1'b0;
        req_a   = {row_q, cmd_col};
        wr_en   = 1'b0;
        wr_a    = {row_q, cmd_col};
        if (is_pre) begin
            burst_d = B_IDLE;
        end else if (rd_ok || wr_ok) begin
            req_v   = rd_ok;
            wr_en   = wr_ok;
            bmask_d = mode_mask;
            bcol_d  = wrap_inc(cmd_col, mode_mask);
            bleft_d = mode_mask[2:0];
            if (mode_mask == '0) burst_d = B_IDLE;
            else                 burst_d = rd_ok ? B_READ : B_WRITE;
        end else if (burst_q != B_IDLE) begin
            req_v   = (burst_q == B_READ);
            req_a   = {row_q, bcol_q};
            wr_en   = (burst_q == B_WRITE);
            wr_a    = {row_q, bcol_q};
            bcol_d  = wrap_inc(bcol_q, bmask_q);
            bleft_d = bleft_q - 3'd1;
            if (bleft_q == 3'd1) burst_d = B_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_a] <= sdram_data_i;
    end

    // Read requests wait CL-2 stages, then the RAM read lands directly in data_o.
    assign out_v = cl3_q ? p2_v : p1_v;
    assign out_a = cl3_q ? p2_a : p1_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v          <= 1'b0;
            p1_a          <= '0;
            p2_v          <= 1'b0;
            p2_a          <= '0;
            sdram_data_oe <= 1'b0;
            sdram_data_o  <= '0;
        end else begin
            p1_v <= req_v;
            p1_a <= req_a;
            p2_v <= p1_v && !flush;
            p2_a <= p1_a;
            if (out_v && !flush) begin
                sdram_data_oe <= 1'b1;
                sdram_data_o  <= mem[out_a];
            end else begin
                sdram_data_oe <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            row_open_q    <= 1'b0;
            cl3_q         <= 1'b0;
            bl_code_q     <= 2'd0;
            err           <= 1'b0;
            err_count     <= 8'd0;
            refresh_count <= 16'd0;
        end else begin
            if (is_act) begin
                row_q      <= sdram_addr[ROW_BITS-1:0];
                row_open_q <= 1'b1;
            end
            if (is_pre) row_open_q <= 1'b0;
            if (is_lm && cl_ok) cl3_q <= sdram_addr[4];
            if (is_lm && bl_ok) bl_code_q <= sdram_addr[1:0];
            if (is_ref) refresh_count <= refresh_count + 16'd1;
            if (viol) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a command-level memory/timing model predicts
// data_o/data_oe every cycle; literal expectations pin the test-plan scenarios.
module tb_sdram_responder;
    localparam logic [2:0] C_LM  = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam int SLOTS = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [11:0] addr = '0;
    logic [15:0] din = '0;
    logic [15:0] data_o;
    logic        data_oe, err;
    logic [7:0]  err_count;
    logic [15:0] refresh_count;

    int n_tests = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Model state
    logic        m_open;
    logic [5:0]  m_row;
    int          m_cl, m_bl, m_viol, m_ref;
    int          m_bstart, m_blast, m_bbl;
    logic        m_brd;
    logic [7:0]  m_bcol0;
    logic [15:0] m_mem [int];
    logic        slot_v [SLOTS];
    logic [15:0] slot_d [SLOTS];
    logic        cap_oe [SLOTS];
    logic [15:0] cap_d  [SLOTS];
    logic [15:0] last_d;

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n),
        .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_addr(addr), .sdram_data_i(din),
        .sdram_data_o(data_o), .sdram_data_oe(data_oe),
        .err(err), .err_count(err_count), .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [7:0] beat_col(input logic [7:0] start, input int i, input int bl);
        logic [7:0] m;
        m = 8'(bl - 1);
        return (start & ~m) | (8'(int'(start) + i) & m);
    endfunction

    function automatic int key(input logic [5:0] r, input logic [7:0] c);
        return int'({r, c});
    endfunction

    function automatic void clear_from(input int from);
        for (int k = from; k < from + 16 && k < SLOTS; k++) slot_v[k] = 1'b0;
    endfunction

    function automatic void model_reset();
        m_open = 1'b0; m_row = '0; m_cl = 2; m_bl = 1; m_viol = 0; m_ref = 0;
        m_bstart = 0; m_blast = -1; m_bbl = 1; m_brd = 1'b0; m_bcol0 = '0; last_d = '0;
        for (int k = 0; k < SLOTS; k++) slot_v[k] = 1'b0;
    endfunction

    // Effect of command c sampled at edge mm, from the command-level rules.
    function automatic void model_cmd(input logic [2:0] c, input logic [11:0] a,
                                      input logic [15:0] d, input int mm);
        logic v, term, in_burst;
        v = 1'b0;
        in_burst = (mm <= m_blast);
        term = (c == C_PRE) || ((c == C_RD || c == C_WR) && m_open);
        if (!term && in_burst && !m_brd)
            m_mem[key(m_row, beat_col(m_bcol0, mm - m_bstart, m_bbl))] = d;
        case (c)
            C_ACT: begin
                if (m_open) v = 1'b1;
                m_open = 1'b1;
                m_row = a[5:0];
            end
            C_PRE: begin
                m_open = 1'b0;
                m_blast = -1;
                clear_from(mm);
            end
            C_REF: begin
                m_ref++;
                if (m_open || in_burst) v = 1'b1;
            end
            C_LM: begin
                if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]); else v = 1'b1;
                if (a[2:0] < 3'd4) m_bl = 1 << a[1:0]; else v = 1'b1;
                if (m_open) v = 1'b1;
            end
            C_RD, C_WR: begin
                if (!m_open) v = 1'b1;
                else begin
                    if (c == C_RD) begin
                        clear_from(mm + m_cl - 1);
                        for (int i = 0; i < m_bl; i++) begin
                            slot_v[mm + m_cl - 1 + i] = 1'b1;
                            slot_d[mm + m_cl - 1 + i] = m_mem[key(m_row, beat_col(a[7:0], i, m_bl))];
                        end
                    end else begin
                        clear_from(mm);
                        m_mem[key(m_row, a[7:0])] = d;
                    end
                    m_bstart = mm; m_blast = mm + m_bl - 1; m_bbl = m_bl;
                    m_brd = (c == C_RD); m_bcol0 = a[7:0];
                end
            end
            default: ;
        endcase
        if (v) m_viol++;
    endfunction

    // Compare DUT data outputs against the model after every edge.
    always @(negedge clk) begin
        int k;
        k = edge_n;
        if (rst_n && k < SLOTS) begin
            cap_oe[k] = data_oe;
            cap_d[k]  = data_o;
            if (slot_v[k]) begin
                check("oe_beat", data_oe, 1);
                check("data_beat", data_o, slot_d[k]);
                last_d = slot_d[k];
            end else begin
                check("oe_idle", data_oe, 0);
                check("data_hold", data_o, last_d);
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [11:0] a, input logic [15:0] d, output int m);
        @(negedge clk);
        {ras_n, cas_n, we_n} = c;
        addr = a;
        din = d;
        m = edge_n + 1;
        model_cmd(c, a, d, m);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [11:0] a, input logic [15:0] d);
        int m;
        issue(c, a, d, m);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 12'h000, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {ras_n, cas_n, we_n} = C_NOP;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int sat255(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    initial begin
        int n, n2, hits;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_data_o", data_o, 16'h0000);
        check("rst_oe", data_oe, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_refresh", refresh_count, 0);
        rst_n = 1'b1;

        // CL2 BL1 single write/read
        cmd(C_LM, 12'h020, 0);
        cmd(C_ACT, 12'h003, 0);
        cmd(C_WR, 12'h010, 16'hBEEF);
        issue(C_RD, 12'h010, 0, n);
        nops(4);
        check("t1_oe_early", cap_oe[n], 0);
        check("t1_oe", cap_oe[n+1], 1);
        check("t1_data", cap_d[n+1], 16'hBEEF);
        check("t1_oe_after", cap_oe[n+2], 0);
        check("t1_err", err, 0);

        // CL3 BL4 wrapped write then wrapped read
        cmd(C_PRE, 0, 0);
        cmd(C_LM, 12'h032, 0);
        cmd(C_ACT, 12'h001, 0);
        cmd(C_WR, 12'h006, 16'h1111);
        cmd(C_NOP, 0, 16'h2222);
        cmd(C_NOP, 0, 16'h3333);
        cmd(C_NOP, 0, 16'h4444);
        nops(1);
        issue(C_RD, 12'h004, 0, n);
        nops(8);
        check("t2_oe_early", cap_oe[n+1], 0);
        check("t2_b0", cap_d[n+2], 16'h3333);
        check("t2_b1", cap_d[n+3], 16'h4444);
        check("t2_b2", cap_d[n+4], 16'h1111);
        check("t2_b3", cap_d[n+5], 16'h2222);
        check("t2_oe_end", cap_oe[n+6], 0);

        // READ interrupting READ: seamless hand-over
        issue(C_RD, 12'h004, 0, n);
        nops(1);
        cmd(C_RD, 12'h006, 0);
        nops(10);
        check("t3_old_b1", cap_d[n+3], 16'h4444);
        check("t3_new_b0", cap_d[n+4], 16'h1111);
        check("t3_new_b3", cap_d[n+7], 16'h4444);
        check("t3_oe_end", cap_oe[n+8], 0);

        // WRITE during read output drops remaining beats
        issue(C_RD, 12'h004, 0, n);
        nops(2);
        cmd(C_WR, 12'h020, 16'h5555);
        cmd(C_NOP, 0, 16'h6666);
        cmd(C_NOP, 0, 16'h7777);
        cmd(C_NOP, 0, 16'h8888);
        nops(4);
        check("t4_oe_before_wr", cap_oe[n+2], 1);
        check("t4_oe_at_wr", cap_oe[n+3], 0);
        issue(C_RD, 12'h022, 0, n2);
        nops(7);
        check("t4_rd_b0", cap_d[n2+2], 16'h7777);
        check("t4_rd_b3", cap_d[n2+5], 16'h6666);

        // PRECHARGE right after READ (CL3): nothing driven
        issue(C_RD, 12'h004, 0, n);
        cmd(C_PRE, 0, 0);
        nops(8);
        hits = 0;
        for (int k = n; k <= n + 8; k++) if (cap_oe[k] === 1'b1) hits++;
        check("t5_no_oe", hits, 0);

        // Violations
        do_reset();
        cmd(C_RD, 12'h000, 0);
        cmd(C_ACT, 12'h000, 0);
        cmd(C_ACT, 12'h000, 0);
        nops(2);
        check("t6_err", err, 1);
        check("t6_err_count", err_count, 2);
        cmd(C_PRE, 0, 0);
        cmd(C_LM, 12'h050, 0);
        nops(1);
        check("t6_bad_cl_count", err_count, 3);
        cmd(C_ACT, 12'h000, 0);
        cmd(C_WR, 12'h030, 16'h7777);
        issue(C_RD, 12'h030, 0, n);
        nops(3);
        check("t6_cl_kept", cap_d[n+1], 16'h7777);
        check("t6_model_count", err_count, sat255(m_viol));

        // Refresh counting and err_count saturation
        do_reset();
        repeat (300) cmd(C_REF, 0, 0);
        nops(2);
        check("t7_refresh", refresh_count, 300);
        check("t7_refresh_model", refresh_count, m_ref);
        check("t7_err", err, 0);
        repeat (260) cmd(C_RD, 12'h000, 0);
        nops(2);
        check("t7_sat", err_count, 255);
        check("t7_sat_model", err_count, sat255(m_viol));

        // Reset during BL8 read beat 3
        do_reset();
        cmd(C_LM, 12'h023, 0);
        cmd(C_ACT, 12'h002, 0);
        cmd(C_WR, 12'h000, 16'hA000);
        for (int i = 1; i < 8; i++) cmd(C_NOP, 0, 16'hA000 + 16'(i));
        issue(C_RD, 12'h000, 0, n);
        nops(4);
        @(posedge clk);
        #2;
        check("t8_beat3_oe", data_oe, 1);
        check("t8_beat3_data", data_o, 16'hA003);
        rst_n = 1'b0;
        #1;
        check("t8_oe_async", data_oe, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmd(C_ACT, 12'h002, 0);
        issue(C_RD, 12'h005, 0, n);
        nops(4);
        check("t8_cl2_early", cap_oe[n], 0);
        check("t8_cl2_oe", cap_oe[n+1], 1);
        check("t8_cl2_data", cap_d[n+1], 16'hA005);
        check("t8_bl1_end", cap_oe[n+2], 0);
        check("t8_err_count", err_count, sat255(m_viol));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
